// File: rtl/relu_arbiter_pkg.sv
// relu_arb_pkg: shared types and sizes for the ReLU arbiter
package relu_arb_pkg;
  localparam int DATA_W = 17;
  localparam int LANES = 4;
  localparam int ADDR_W = 10;
  localparam int MAX_BURST = 16;
  localparam int RELU_LAT = 1;
  localparam int BEAT_W = LANES * DATA_W;
  localparam int CNT_W = $clog2(MAX_BURST);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  typedef struct packed {
    logic valid;
    logic id;
    logic [ADDR_W-1:0] addr;
    logic last;
  } tag_t;
endpackage

// File: rtl/relu_arbiter_if.sv
// relu_arbiter_if: requester, ReLU and response signals of the arbiter
interface relu_arbiter_if;
  import relu_arb_pkg::*;
  logic req0_valid, req0_ready, req0_last, req1_valid, req1_ready, req1_last;
  logic [BEAT_W-1:0] req0_data, req1_data, rsp_data;
  logic [ADDR_W-1:0] req0_addr, req1_addr, rsp_addr;
  logic relu_ready_in, relu_ready_out, rsp_valid, rsp_id, rsp_last, busy, err;
  logic [DATA_W-1:0] relu_in0, relu_in1, relu_in2, relu_in3;
  logic [DATA_W-1:0] relu_out0, relu_out1, relu_out2, relu_out3;
  modport slave (
    input req0_valid, req0_data, req0_addr, req0_last,
    input req1_valid, req1_data, req1_addr, req1_last,
    input relu_ready_out, relu_out0, relu_out1, relu_out2, relu_out3,
    output req0_ready, req1_ready, relu_ready_in, relu_in0, relu_in1, relu_in2, relu_in3,
    output rsp_valid, rsp_id, rsp_addr, rsp_data, rsp_last, busy, err
  );
  modport master (
    output req0_valid, req0_data, req0_addr, req0_last,
    output req1_valid, req1_data, req1_addr, req1_last,
    output relu_ready_out, relu_out0, relu_out1, relu_out2, relu_out3,
    input req0_ready, req1_ready, relu_ready_in, relu_in0, relu_in1, relu_in2, relu_in3,
    input rsp_valid, rsp_id, rsp_addr, rsp_data, rsp_last, busy, err
  );
endinterface

// File: rtl/relu_arbiter_tag_pipe.sv
// relu_tag_pipe: tag delay line aligning beat owner/address with the ReLU result
module relu_tag_pipe
  import relu_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q,
  output logic busy
);
  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | pipe_q[i].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    else pipe_q <= pipe_d;
  end
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/relu_arbiter.sv
// relu_arbiter: round-robin burst arbiter sharing one 4-lane ReLU between two requesters
module relu_arbiter
  import relu_arb_pkg::*;
(
  input logic clk,
  input logic rst,
  relu_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic rr_q, rr_d, issue_q, issue_d, err_q, err_d, gid, close, pipe_busy;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] lanes_q, lanes_d, rsp_data_q, rsp_data_d;
  tag_t tag_in, tag_out, rsp_tag_q, rsp_tag_d;
  always_comb begin
    gid = state_q == GRANT1;
    issue_d = (state_q == GRANT0 & bus.req0_valid) | (gid & bus.req1_valid);
    tag_in = '{valid: issue_d, id: gid, addr: gid ? bus.req1_addr : bus.req0_addr,
               last: gid ? bus.req1_last : bus.req0_last};
    close = issue_d & (tag_in.last | cnt_q == CNT_W'(MAX_BURST - 1));
    cnt_d = close ? '0 : cnt_q + CNT_W'(issue_d);
    rr_d = close ? ~gid : rr_q;
    // rr_q picks the winner only when both requesters are valid in IDLE
    state_d = close ? IDLE : state_q != IDLE ? state_q :
              (bus.req0_valid & (~bus.req1_valid | ~rr_q)) ? GRANT0 :
              bus.req1_valid ? GRANT1 : IDLE;
    lanes_d = issue_d ? (gid ? bus.req1_data : bus.req0_data) : lanes_q;
    rsp_tag_d = (tag_out.valid & bus.relu_ready_out) ? tag_out :
                '{valid: 1'b0, id: rsp_tag_q.id, addr: rsp_tag_q.addr, last: rsp_tag_q.last};
    rsp_data_d = rsp_tag_d.valid ? {bus.relu_out3, bus.relu_out2, bus.relu_out1, bus.relu_out0} : rsp_data_q;
    err_d = err_q | (tag_out.valid ^ bus.relu_ready_out);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      cnt_q <= '0;
      issue_q <= 1'b0;
      lanes_q <= '0;
      rsp_tag_q <= '0;
      rsp_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      issue_q <= issue_d;
      lanes_q <= lanes_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_data_q <= rsp_data_d;
      err_q <= err_d;
    end
  end
  relu_tag_pipe #(.DEPTH(1 + RELU_LAT)) u_tag_pipe (
    .clk(clk), .rst(rst), .d(tag_in), .q(tag_out), .busy(pipe_busy)
  );
  assign bus.req0_ready = state_q == GRANT0;
  assign bus.req1_ready = gid;
  assign bus.relu_ready_in = issue_q;
  assign bus.relu_in0 = lanes_q[0*DATA_W +: DATA_W];
  assign bus.relu_in1 = lanes_q[1*DATA_W +: DATA_W];
  assign bus.relu_in2 = lanes_q[2*DATA_W +: DATA_W];
  assign bus.relu_in3 = lanes_q[3*DATA_W +: DATA_W];
  assign bus.rsp_valid = rsp_tag_q.valid;
  assign bus.rsp_id = rsp_tag_q.id;
  assign bus.rsp_addr = rsp_tag_q.addr;
  assign bus.rsp_last = rsp_tag_q.last;
  assign bus.rsp_data = rsp_data_q;
  assign bus.busy = state_q != IDLE | pipe_busy;
  assign bus.err = err_q;
endmodule

// File: tb/tb_relu_arbiter.sv
// tb_relu_arbiter: randomized scoreboard bench for the ReLU arbiter with a behavioural ReLU
module tb_relu_arbiter;
  import relu_arb_pkg::*;
  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic last;
  } beat_t;
  typedef struct {
    logic id;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] data;
    logic last;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, hold0 = 1'b0, force_rdy = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0, n_rsp = 0;
  logic took0, took1;
  beat_t q0[$], q1[$];
  exp_t exp_q[$];
  exp_t e;
  logic acc_log[$];
  int acc_cyc[$];
  relu_arbiter_if bus();
  relu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [DATA_W-1:0] lane_relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction
  always @(posedge clk) begin
    bus.relu_ready_out <= !rst & (bus.relu_ready_in | force_rdy);
    bus.relu_out0 <= lane_relu(bus.relu_in0);
    bus.relu_out1 <= lane_relu(bus.relu_in1);
    bus.relu_out2 <= lane_relu(bus.relu_in2);
    bus.relu_out3 <= lane_relu(bus.relu_in3);
  end
  function automatic logic [BEAT_W-1:0] relu_ref(input logic [BEAT_W-1:0] d);
    logic [BEAT_W-1:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = $signed(d[i*DATA_W +: DATA_W]);
      r[i*DATA_W +: DATA_W] = v < 0 ? '0 : DATA_W'(v);
    end
    return r;
  endfunction
  function automatic beat_t mk(input int addr, input logic last);
    beat_t b;
    b.data = BEAT_W'({$urandom(), $urandom(), $urandom()});
    b.addr = ADDR_W'(addr);
    b.last = last;
    return b;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask
  task automatic record(input logic id, input beat_t b);
    acc_log.push_back(id);
    acc_cyc.push_back(cyc);
    exp_q.push_back('{id, b.addr, relu_ref(b.data), b.last, cyc});
  endtask
  task automatic drive();
    bus.req0_valid = q0.size() != 0 && !hold0;
    bus.req1_valid = q1.size() != 0;
    if (q0.size() != 0) {bus.req0_data, bus.req0_addr, bus.req0_last} = {q0[0].data, q0[0].addr, q0[0].last};
    if (q1.size() != 0) {bus.req1_data, bus.req1_addr, bus.req1_last} = {q1[0].data, q1[0].addr, q1[0].last};
  endtask
  initial begin
    drive();
    forever begin
      @(negedge clk);
      took0 = bus.req0_valid & bus.req0_ready & !rst;
      took1 = bus.req1_valid & bus.req1_ready & !rst;
      if (took0) record(1'b0, q0[0]);
      if (took1) record(1'b1, q1[0]);
      @(posedge clk);
      #1;
      if (took0) void'(q0.pop_front());
      if (took1) void'(q1.pop_front());
      drive();
    end
  end
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_addr", bus.rsp_addr, e.addr);
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_last", bus.rsp_last, e.last);
        chk("rsp_latency", cyc - e.cyc, 2 + RELU_LAT);
        n_rsp++;
      end
    end
  end
  task automatic wait_acc(input int n);
    for (int k = 0; k < 300 && acc_log.size() < n; k++) begin
      @(posedge clk);
      #2;
    end
    chk("accept_count", acc_log.size(), n);
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic e2 [6];
    int base;
    beat_t b;
    e2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) q0.push_back(mk(100 + i, i % 2 == 1));
    for (int i = 0; i < 2; i++) q1.push_back(mk(200 + i, i == 1));
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_relu_ready_in", bus.relu_ready_in, 0);
    chk("reset_req0_ready", bus.req0_ready, 0);
    chk("reset_req1_ready", bus.req1_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_acc(6);
    for (int i = 0; i < 6; i++) chk("rr_order", acc_log[i], e2[i]);
    chk("idle_gap_a", acc_cyc[2] - acc_cyc[1], 2);
    chk("idle_gap_b", acc_cyc[4] - acc_cyc[3], 2);
    drain();
    chk("idle_busy", bus.busy, 0);
    clear_logs();
    b.data = {17'h10000, 17'd7, 17'd0, 17'h1FFFD};
    for (int i = 0; i < 3; i++) begin
      b.addr = ADDR_W'(5 + i);
      b.last = i == 2;
      q0.push_back(b);
    end
    wait_acc(3);
    for (int i = 0; i < 3; i++) chk("single_id", acc_log[i], 0);
    drain();
    clear_logs();
    for (int i = 0; i < 4; i++) q0.push_back(mk(300 + i, i == 3));
    wait_acc(1);
    for (int i = 0; i < 2; i++) q1.push_back(mk(400 + i, i == 1));
    wait_acc(2);
    hold0 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("hold_req1_ready", bus.req1_ready, 0);
      chk("hold_req0_ready", bus.req0_ready, 1);
    end
    hold0 = 1'b0;
    wait_acc(6);
    for (int i = 0; i < 6; i++) chk("hold_order", acc_log[i], i >= 4);
    drain();
    clear_logs();
    for (int i = 0; i < 20; i++) q1.push_back(mk(500 + i, 1'b0));
    wait_acc(1);
    q0.push_back(mk(600, 1'b1));
    wait_acc(21);
    for (int i = 0; i < 21; i++) chk("max_burst_order", acc_log[i], i != 16);
    drain();
    chk("stall_grant_held", bus.req1_ready, 1);
    chk("stall_busy", bus.busy, 1);
    do_reset();
    @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_ready1", bus.req1_ready, 0);
    clear_logs();
    for (int i = 0; i < 2; i++) q0.push_back(mk(700 + i, i == 1));
    wait_acc(2);
    chk("inflight_busy", bus.busy, 1);
    base = n_rsp;
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_busy", bus.busy, 0);
    chk("flush_rsp_valid", bus.rsp_valid, 0);
    repeat (4) @(negedge clk);
    chk("flush_no_rsp", n_rsp, base);
    chk("flush_err", bus.err, 0);
    clear_logs();
    q1.push_back(mk(800, 1'b1));
    wait_acc(1);
    drain();
    chk("clean_after_reset", n_rsp, base + 1);
    @(posedge clk);
    #2 force_rdy = 1'b1;
    @(posedge clk);
    #2 force_rdy = 1'b0;
    @(posedge clk);
    #2;
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", bus.err, 1);
      chk("err_no_rsp", bus.rsp_valid, 0);
    end
    chk("err_rsp_count", n_rsp, base + 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", bus.err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
